// File: rtl/hazard3_fetch_align_buf.sv
// hazard3_fetch_align_buf
//
// Halfword-granular alignment buffer between the instruction fetch bus and
// the compressed-instruction expander. Naturally aligned 32-bit fetch words
// are split into halfwords and appended to a shift-down queue. The two oldest
// halfwords are presented as a 32-bit window, so any instruction, including
// a 32-bit one straddling a word boundary, always starts at bit 0.
//
// Optional feature macro: HAZARD3_ALIGN_BUF_ERR_EN
//   When defined, each halfword carries a bus-error flag (fetch_err in,
//   cir_err out). When undefined, those ports and the flag storage are absent.
//
// Ports:
//   clk             in   clock
//   rst_n           in   asynchronous active-low reset
//   fetch_data      in   32-bit naturally aligned fetch word
//   fetch_valid     in   fetch_data valid this cycle
//   fetch_ready     out  a word can be accepted this cycle
//   fetch_err       in   bus error on this word (ERR_EN only)
//   flush           in   redirect: discard everything buffered / in flight
//   flush_hw_offset in   bit 1 of the redirect target
//   cir             out  halfword 0 at [15:0], halfword 1 at [31:16]
//   cir_vld         out  valid halfwords in cir (0..2)
//   cir_use         in   halfwords consumed this cycle (clamped to cir_vld)
//   cir_err         out  per-halfword error flags (ERR_EN only)
//   cir_instr_rdy   out  cir holds one complete instruction

module hazard3_fetch_align_buf #(
  parameter int DEPTH_HW = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_data,
  input  logic        fetch_valid,
`ifdef HAZARD3_ALIGN_BUF_ERR_EN
  input  logic        fetch_err,
`endif
  output logic        fetch_ready,
  input  logic        flush,
  input  logic        flush_hw_offset,
  output logic [31:0] cir,
  output logic [1:0]  cir_vld,
  input  logic [1:0]  cir_use,
`ifdef HAZARD3_ALIGN_BUF_ERR_EN
  output logic [1:0]  cir_err,
`endif
  output logic        cir_instr_rdy
);

  // Queue storage: entry 0 is the oldest halfword.
  logic [15:0] hw_r [DEPTH_HW];
  logic [3:0]  level_r;
  logic        drop_low_r;

  // Queue extended with two zero entries so a shift by 2 never indexes
  // past the end of the array.
  logic [15:0] hw_ext_s   [DEPTH_HW+2];
  logic [15:0] hw_shift_s [DEPTH_HW];
  logic [15:0] hw_next_s  [DEPTH_HW];

  logic [1:0]  cir_vld_s;
  logic [1:0]  use_eff_s;
  logic        push_s;
  logic [3:0]  push_hw_s;
  logic [3:0]  base_s;
  logic [3:0]  level_next_s;
  logic        drop_low_next_s;

  // Ready depends on registered level only: no path from cir_use.
  assign fetch_ready = (level_r <= 4'(DEPTH_HW - 2));

  assign cir_vld_s = (level_r >= 4'd2) ? 2'd2 : level_r[1:0];
  assign cir_vld   = cir_vld_s;

  // Invalid halfwords of the window read as zero.
  assign cir[15:0]  = (cir_vld_s != 2'd0) ? hw_r[0] : 16'd0;
  assign cir[31:16] = (cir_vld_s == 2'd2) ? hw_r[1] : 16'd0;

  // A lone halfword is a complete instruction only if it is compressed.
  assign cir_instr_rdy = (cir_vld_s == 2'd2) ||
                         ((cir_vld_s == 2'd1) && (hw_r[0][1:0] != 2'b11));

  // Clamp consumption to the number of valid halfwords, compute push size.
  always_comb begin
    if (cir_use > cir_vld_s) begin
      use_eff_s = cir_vld_s;
    end else begin
      use_eff_s = cir_use;
    end
    push_s    = fetch_valid && fetch_ready && !flush;
    push_hw_s = drop_low_r ? 4'd1 : 4'd2;
    base_s    = level_r - {2'b00, use_eff_s};
  end

  // Next level and next drop_low state; flush dominates pop and push.
  always_comb begin
    if (flush) begin
      level_next_s    = 4'd0;
      drop_low_next_s = flush_hw_offset;
    end else if (push_s) begin
      level_next_s    = base_s + push_hw_s;
      drop_low_next_s = 1'b0;
    end else begin
      level_next_s    = base_s;
      drop_low_next_s = drop_low_r;
    end
  end

  // Build the zero-extended view of the queue.
  always_comb begin
    for (int i = 0; i < DEPTH_HW; i++) begin
      hw_ext_s[i] = hw_r[i];
    end
    hw_ext_s[DEPTH_HW]   = 16'd0;
    hw_ext_s[DEPTH_HW+1] = 16'd0;
  end

  // Shift down by the consumed count, then land new halfwords at base_s.
  always_comb begin
    for (int i = 0; i < DEPTH_HW; i++) begin
      case (use_eff_s)
        2'd0:    hw_shift_s[i] = hw_ext_s[i];
        2'd1:    hw_shift_s[i] = hw_ext_s[i+1];
        2'd2:    hw_shift_s[i] = hw_ext_s[i+2];
        default: hw_shift_s[i] = hw_ext_s[i];
      endcase
      if (push_s && (base_s == 4'(i))) begin
        hw_next_s[i] = drop_low_r ? fetch_data[31:16] : fetch_data[15:0];
      end else if (push_s && !drop_low_r && ((base_s + 4'd1) == 4'(i))) begin
        hw_next_s[i] = fetch_data[31:16];
      end else begin
        hw_next_s[i] = hw_shift_s[i];
      end
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r    <= 4'd0;
      drop_low_r <= 1'b0;
      for (int i = 0; i < DEPTH_HW; i++) begin
        hw_r[i] <= 16'd0;
      end
    end else begin
      level_r    <= level_next_s;
      drop_low_r <= drop_low_next_s;
      for (int i = 0; i < DEPTH_HW; i++) begin
        hw_r[i] <= hw_next_s[i];
      end
    end
  end

`ifdef HAZARD3_ALIGN_BUF_ERR_EN
  // Error flags move in lockstep with the halfword data.
  logic err_r      [DEPTH_HW];
  logic err_ext_s  [DEPTH_HW+2];
  logic err_next_s [DEPTH_HW];

  assign cir_err[0] = (cir_vld_s != 2'd0) ? err_r[0] : 1'b0;
  assign cir_err[1] = (cir_vld_s == 2'd2) ? err_r[1] : 1'b0;

  // Zero-extended view of the error flags.
  always_comb begin
    for (int i = 0; i < DEPTH_HW; i++) begin
      err_ext_s[i] = err_r[i];
    end
    err_ext_s[DEPTH_HW]   = 1'b0;
    err_ext_s[DEPTH_HW+1] = 1'b0;
  end

  // Shift and land error flags exactly like the data.
  always_comb begin
    for (int i = 0; i < DEPTH_HW; i++) begin
      if (push_s && (base_s == 4'(i))) begin
        err_next_s[i] = fetch_err;
      end else if (push_s && !drop_low_r && ((base_s + 4'd1) == 4'(i))) begin
        err_next_s[i] = fetch_err;
      end else begin
        case (use_eff_s)
          2'd0:    err_next_s[i] = err_ext_s[i];
          2'd1:    err_next_s[i] = err_ext_s[i+1];
          2'd2:    err_next_s[i] = err_ext_s[i+2];
          default: err_next_s[i] = err_ext_s[i];
        endcase
      end
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_HW; i++) begin
        err_r[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH_HW; i++) begin
        err_r[i] <= err_next_s[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard3_fetch_align_buf.sv
// Self-checking bench for hazard3_fetch_align_buf: directed scenarios plus
// randomized traffic, all compared against a halfword-queue reference model.

module tb_hazard3_fetch_align_buf;

  localparam int DEPTH = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_err;
  logic        fetch_ready;
  logic        flush;
  logic        flush_hw_offset;
  logic [31:0] cir;
  logic [1:0]  cir_vld;
  logic [1:0]  cir_use;
  logic [1:0]  cir_err;
  logic        cir_instr_rdy;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of halfwords plus per-halfword error flags.
  logic [15:0] mq[$];
  logic        me[$];
  logic        m_drop;

  // Values observed at the start of the most recent step.
  logic [31:0] o_cir;
  logic [1:0]  o_vld;
  logic        o_rdy;
  logic        o_frdy;
  logic [1:0]  o_err;

  always #5 clk = ~clk;

`ifndef HAZARD3_ALIGN_BUF_ERR_EN
  assign cir_err = 2'b00;
`endif

  hazard3_fetch_align_buf #(.DEPTH_HW(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_data      (fetch_data),
    .fetch_valid     (fetch_valid),
`ifdef HAZARD3_ALIGN_BUF_ERR_EN
    .fetch_err       (fetch_err),
`endif
    .fetch_ready     (fetch_ready),
    .flush           (flush),
    .flush_hw_offset (flush_hw_offset),
    .cir             (cir),
    .cir_vld         (cir_vld),
    .cir_use         (cir_use),
`ifdef HAZARD3_ALIGN_BUF_ERR_EN
    .cir_err         (cir_err),
`endif
    .cir_instr_rdy   (cir_instr_rdy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic step(input logic fv, input logic [31:0] fd, input logic fe,
                      input logic fl, input logic off, input logic [1:0] u);
    int n;
    int ev;
    int ue;
    logic [31:0] ec;
    logic [1:0]  ee;
    logic        er;
    logic        acc;
    @(negedge clk);
    o_cir  = cir;
    o_vld  = cir_vld;
    o_rdy  = cir_instr_rdy;
    o_frdy = fetch_ready;
    o_err  = cir_err;
    n  = mq.size();
    ev = (n >= 2) ? 2 : n;
    ec = 32'd0;
    ee = 2'b00;
    if (ev >= 1) begin
      ec[15:0] = mq[0];
      ee[0]    = me[0];
    end
    if (ev == 2) begin
      ec[31:16] = mq[1];
      ee[1]     = me[1];
    end
    er = (ev == 2) || ((ev == 1) && (ec[1:0] != 2'b11));
    check_val("cir", cir, ec);
    check_val("cir_vld", 32'(cir_vld), 32'(ev));
    check_val("instr_rdy", 32'(cir_instr_rdy), 32'(er));
    check_val("fetch_ready", 32'(fetch_ready), 32'(n <= DEPTH - 2));
`ifdef HAZARD3_ALIGN_BUF_ERR_EN
    check_val("cir_err", 32'(cir_err), 32'(ee));
`endif
    fetch_valid     = fv;
    fetch_data      = fd;
    fetch_err       = fe;
    flush           = fl;
    flush_hw_offset = off;
    cir_use         = u;
    acc = fv && (n <= DEPTH - 2) && !fl;
    if (fl) begin
      mq.delete();
      me.delete();
      m_drop = off;
    end else begin
      ue = (int'(u) > ev) ? ev : int'(u);
      repeat (ue) begin
        void'(mq.pop_front());
        void'(me.pop_front());
      end
      if (acc) begin
        if (!m_drop) begin
          mq.push_back(fd[15:0]);
          me.push_back(fe);
        end
        mq.push_back(fd[31:16]);
        me.push_back(fe);
        m_drop = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic [1:0] u);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, u);
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    step(1'b1, d, e, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_valid = 1'b0; fetch_data = 32'd0; fetch_err = 1'b0;
    flush = 1'b0; flush_hw_offset = 1'b0; cir_use = 2'd0;
    m_drop = 1'b0;
    #3;
    check_val("rst_cir", cir, 32'd0);
    check_val("rst_vld", 32'(cir_vld), 32'd0);
    check_val("rst_instr_rdy", 32'(cir_instr_rdy), 32'd0);
    check_val("rst_err", 32'(cir_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single 32-bit instruction, then consumed completely.
    push(32'h00A30313, 1'b0);
    check_val("t0_frdy", 32'(o_frdy), 32'd1);
    idle(2'd2);
    check_val("t1_cir", o_cir, 32'h00A30313);
    check_val("t1_vld", 32'(o_vld), 32'd2);
    check_val("t1_rdy", 32'(o_rdy), 32'd1);

    // Two compressed instructions, consumed one at a time.
    push(32'h05134501, 1'b0);
    check_val("t1_empty", 32'(o_vld), 32'd0);
    idle(2'd1);
    check_val("t2_rdy", 32'(o_rdy), 32'd1);
    idle(2'd1);
    check_val("t2_cir", o_cir, 32'h00000513);
    check_val("t2_vld", 32'(o_vld), 32'd1);

    // 32-bit instruction straddling a word boundary.
    push(32'h03134501, 1'b0);
    push(32'h000000A3, 1'b0);
    idle(2'd1);
    check_val("t3_pre", o_cir, 32'h03134501);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 2'd0);
    check_val("t3_cir", o_cir, 32'h00A30313);
    check_val("t3_vld", 32'(o_vld), 32'd2);

    // Redirect to an odd halfword: only the upper half of the first word.
    push(32'hBEEFDEAD, 1'b0);
    push(32'h12345678, 1'b0);
    check_val("t4_cir", o_cir, 32'h0000BEEF);
    check_val("t4_vld", 32'(o_vld), 32'd1);
    check_val("t4_rdy", 32'(o_rdy), 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 2'd0);
    check_val("t4_fill", o_cir, 32'h5678BEEF);

    // Fill to full, check order on drain, then flush at full.
    push(32'h11112222, 1'b0);
    push(32'h33334444, 1'b0);
    push(32'h55556666, 1'b0);
    push(32'h77778888, 1'b0);
    check_val("t5_full", 32'(o_frdy), 32'd0);
    idle(2'd2);
    check_val("t5_full_use", 32'(o_frdy), 32'd0);
    check_val("t5_w0", o_cir, 32'h11112222);
    idle(2'd2);
    check_val("t5_w1", o_cir, 32'h33334444);
    idle(2'd2);
    check_val("t5_w2", o_cir, 32'h55556666);
    idle(2'd0);
    check_val("t5_drained", 32'(o_vld), 32'd0);
    push(32'h11112222, 1'b0);
    push(32'h33334444, 1'b0);
    push(32'h55556666, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 2'd2);
    check_val("t5_full2", 32'(o_frdy), 32'd0);
    idle(2'd0);
    check_val("t5_flushed", 32'(o_vld), 32'd0);
    check_val("t5_flush_frdy", 32'(o_frdy), 32'd1);

`ifdef HAZARD3_ALIGN_BUF_ERR_EN
    // Error flags follow their halfwords.
    push(32'hAAAA5555, 1'b1);
    push(32'h0000CCCC, 1'b0);
    idle(2'd1);
    check_val("t6_err_both", 32'(o_err), 32'd3);
    idle(2'd0);
    check_val("t6_err_shift", 32'(o_err), 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 2'd0);
`endif

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd2);
    end

    // Reset asserted mid-operation clears outputs immediately.
    push(32'hCAFEF00D, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    fetch_valid = 1'b0;
    flush = 1'b0;
    cir_use = 2'd0;
    #1;
    check_val("mid_rst_cir", cir, 32'd0);
    check_val("mid_rst_vld", 32'(cir_vld), 32'd0);
    check_val("mid_rst_rdy", 32'(cir_instr_rdy), 32'd0);
    check_val("mid_rst_err", 32'(cir_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    me.delete();
    m_drop = 1'b0;
    push(32'h00A30313, 1'b0);
    idle(2'd2);
    check_val("post_rst_cir", o_cir, 32'h00A30313);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard3_fetch_align_buf.md
# hazard3_fetch_align_buf

Halfword-granular instruction alignment buffer between the fetch bus and the compressed-instruction expander. It accepts naturally aligned 32-bit fetch words, repacks them into a halfword queue, and presents the oldest two halfwords as a 32-bit window. The window is realigned so that 32-bit instructions straddling a word boundary, and 16-bit instructions at odd halfword offsets, always appear at bit 0. The window feeds the expander's `instr_in` directly, and the decode stage returns how many halfwords it consumed.

## Interface
Parameters:
- `DEPTH_HW`, default 6: queue depth in halfwords; legal values are even and in the range 4–8.

Ports:
- `clk`  in  1: sole clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `fetch_data`  in  32: naturally aligned fetch word.
- `fetch_valid`  in  1: `fetch_data` is valid this cycle.
- `fetch_ready`  out  1: a word can be accepted this cycle.
- `fetch_err`  in  1: bus error on this word. Present only with `HAZARD3_ALIGN_BUF_ERR_EN`.
- `flush`  in  1: jump/trap redirect; discard all buffered and in-flight data.
- `flush_hw_offset`  in  1: bit 1 of the redirect target.
- `cir`  out  32: halfword 0 at `[15:0]`, halfword 1 at `[31:16]`.
- `cir_vld`  out  2: number of valid halfwords in `cir` (0, 1 or 2).
- `cir_use`  in  2: halfwords consumed this cycle (0, 1 or 2).
- `cir_err`  out  2: per-halfword error flags. Present only with `HAZARD3_ALIGN_BUF_ERR_EN`.
- `cir_instr_rdy`  out  1: `cir` holds one complete instruction. Asserted when `cir_vld >= 1` and `cir[1:0] != 2'b11`, or when `cir_vld == 2`.

## Operation
- Queue state:
  - `level` counts occupied halfwords, range 0..`DEPTH_HW`.
  - Entry 0 is the oldest halfword.
  - Storage is a shift-down array. No pointers, so no wrap-around logic.
- Push: a word is accepted when `fetch_valid && fetch_ready && !flush`. It appends 2 halfwords (low first). If `drop_low` is set, only the upper halfword is appended (1 halfword).
- `drop_low` register:
  - Set on `flush` when `flush_hw_offset == 1`.
  - Cleared on `flush` when `flush_hw_offset == 0`.
  - Cleared on the first accepted word after the flush.
- Pop: entries shift down by `cir_use`. `cir_use > cir_vld` is a protocol violation; the block clamps the effective use to `cir_vld`.
- Simultaneous push and pop: `level_next = level - use_eff + push_hw`. New halfwords land at index `level - use_eff`.
- `fetch_ready` is `level <= DEPTH_HW - 2`, taken from the registered `level` only. There is no combinational path from `cir_use` to `fetch_ready`.
- `cir` and `cir_vld` are driven from registered entries 0–1 and `min(level, 2)`. Invalid halfwords in `cir` read as 0.
- Flush:
  - Next-cycle `level` is 0, regardless of `cir_use` or a push in the same cycle.
  - A fetch beat presented in the flush cycle is dropped. `fetch_ready` is still reported so the bus does not stall.
- Stale-data rule: the fetch unit discards responses to pre-flush requests; this block performs no tagging.

## Timing
- Latency: a word accepted in cycle N appears on `cir` in cycle N+1 (registered).
- Throughput: one word per cycle, sustained while `cir_use == 2` each cycle.
- Values in and immediately after reset:
  - `level = 0`, `drop_low = 0`, `cir = 0`, `cir_vld = 0`, `cir_instr_rdy = 0`, `cir_err = 0`.
  - `fetch_ready = 1` once reset is released.
- Reset asserted mid-operation clears all state asynchronously. Outputs return to their reset values within the same cycle.
- Full: at `level == DEPTH_HW - 1` or `DEPTH_HW`, `fetch_ready = 0`, even if `cir_use` would free space this cycle.
- Empty: `cir_vld = 0`. `cir_use` must be 0; any nonzero value is clamped.

## Configuration
- `HAZARD3_ALIGN_BUF_ERR_EN` defined:
  - Each halfword entry carries an error bit copied from `fetch_err` on push.
  - `cir_err[i]` is valid for each valid halfword `i`.
  - The bits shift and flush with the data.
- Not defined: the `fetch_err` and `cir_err` ports are absent and no error storage is built.

## Test plan
- Reset, then push `0x00A30313`: next cycle `cir = 0x00A30313`, `cir_vld = 2`, `cir_instr_rdy = 1`. With `cir_use = 2`, `level` returns to 0.
- Push `0x0513_4501` (two compressed instructions): `cir_instr_rdy = 1`. After `cir_use = 1`, `cir = 0x00000513`, `cir_vld = 1`.
- Push `0x0313_4501`, then `0x000000A3`. Consume 1: `cir = 0x00A30313` (straddling 32-bit instruction), `cir_vld = 2`.
- `flush` with `flush_hw_offset = 1`, then push `0xBEEF_DEAD`: `cir = 0x0000BEEF`, `cir_vld = 1`. The next push fills `cir[31:16]` with its low halfword.
- Push every cycle with `cir_use = 0` and `DEPTH_HW = 6`: after 3 words `fetch_ready = 0` and `level = 6`. Word order must be preserved on drain. `flush` at full gives `level = 0` next cycle.
- With `HAZARD3_ALIGN_BUF_ERR_EN`: push a word with `fetch_err = 1` → `cir_err = 2'b11`. After `cir_use = 1` following a clean word, the per-halfword error flags track the shifted data.
